// File: rtl/sgd_loss_sched_pkg.sv
// Shared types and constants for the serial loss read-side scheduler.
package sgd_loss_sched_pkg;

  localparam int unsigned ENGINE_NUM     = 8;
  localparam int unsigned FIFO_RD_LAT    = 1;
  localparam int unsigned REG_STAGES     = 2;
  localparam int unsigned ADD_TREE_DEPTH = $clog2(ENGINE_NUM);
  // b must arrive together with the adder-tree sum of the same sample
  localparam int unsigned B_LAT_DEFAULT  = FIFO_RD_LAT + REG_STAGES + ADD_TREE_DEPTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Pops closer than 2 cycles apart would read stale empty flags
  function automatic logic [3:0] eff_gap(input logic [3:0] gap);
    return (gap < 4'd2) ? 4'd2 : gap;
  endfunction

endpackage

// File: rtl/sgd_pulse_delay.sv
// Fixed-depth pulse delay line with synchronous clear; reports in-flight pulses.
module sgd_pulse_delay #(
  parameter int unsigned DEPTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic pending
);

  localparam logic [DEPTH-1:0] HEAD_MASK = {DEPTH{1'b1}} >> 1;

  logic [DEPTH-1:0] stg;
  logic [DEPTH-1:0] din_v;

  assign din_v = DEPTH'(din);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg <= '0;
    end else if (clr) begin
      stg <= '0;
    end else begin
      stg <= (stg << 1) | din_v;
    end
  end

  assign dout = stg[DEPTH-1];
  // The tail is being issued this cycle, so only earlier stages still count
  assign pending = |(stg & HEAD_MASK);

endmodule

// File: rtl/sgd_loss_sched.sv
// Read-side scheduler: pops engine FIFOs together, pops b after a fixed latency.
module sgd_loss_sched
  import sgd_loss_sched_pkg::*;
#(
  parameter int unsigned ENGINE_NUM   = sgd_loss_sched_pkg::ENGINE_NUM,
  parameter int unsigned B_LAT        = B_LAT_DEFAULT,
  parameter int unsigned SKEW_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      num_samples,
  input  logic [3:0]            gap_cfg,
  input  logic [ENGINE_NUM-1:0] a_empty,
  input  logic                  b_empty,
  output logic [ENGINE_NUM-1:0] a_rd_en,
  output logic                  b_rd_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      issued_cnt,
  output logic                  skew_err
);

  localparam int unsigned SKEW_W = $clog2(SKEW_TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   n_lat;
  logic [3:0]         gap_cnt;
  logic [SKEW_W-1:0]  skew_cnt;
  logic               pop_q;
  logic               dl_pending;
  logic               all_ready;
  logic               skew_cyc;
  logic               pop_ok;

  assign all_ready = (a_empty == '0);
  assign skew_cyc  = (a_empty != '0) && (a_empty != '1);
  assign pop_ok    = (state == RUN) && all_ready && !b_empty &&
                     (gap_cnt == '0) && (issued_cnt < n_lat);

  assign a_rd_en = {ENGINE_NUM{pop_q}};

  sgd_pulse_delay #(
    .DEPTH (B_LAT)
  ) u_b_delay (
    .clk     (clk),
    .rst     (rst),
    .clr     (abort),
    .din     (pop_q),
    .dout    (b_rd_en),
    .pending (dl_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      n_lat      <= '0;
      gap_cnt    <= '0;
      skew_cnt   <= '0;
      pop_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      issued_cnt <= '0;
      skew_err   <= 1'b0;
    end else begin
      pop_q <= 1'b0;
      done  <= 1'b0;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 4'd1;

      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        skew_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              n_lat      <= num_samples;
              issued_cnt <= '0;
              skew_err   <= 1'b0;
              skew_cnt   <= '0;
              gap_cnt    <= '0;
              busy       <= 1'b1;
              state      <= (num_samples == '0) ? DRAIN : RUN;
            end
          end
          RUN: begin
            if (skew_cyc) begin
              if (skew_cnt != SKEW_W'(SKEW_TIMEOUT)) skew_cnt <= skew_cnt + SKEW_W'(1);
              if (skew_cnt == SKEW_W'(SKEW_TIMEOUT - 1)) skew_err <= 1'b1;
            end else begin
              skew_cnt <= '0;
            end
            if (pop_ok) begin
              pop_q      <= 1'b1;
              issued_cnt <= issued_cnt + CNT_W'(1);
              gap_cnt    <= eff_gap(gap_cfg) - 4'd1;
              if (issued_cnt + CNT_W'(1) == n_lat) state <= DRAIN;
            end else if (issued_cnt >= n_lat) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            // The final a-pop strobe has not entered the delay line yet
            if (!pop_q && !dl_pending) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sgd_loss_sched.sv
// Directed bench for sgd_loss_sched with hand-derived cycle expectations.
module tb_sgd_loss_sched;

  localparam int unsigned EN = 8;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] num_samples;
  logic [3:0]    gap_cfg;
  logic [EN-1:0] a_empty;
  logic          b_empty;
  logic [EN-1:0] a_rd_en;
  logic          b_rd_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] issued_cnt;
  logic          skew_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int a_n = 0, b_n = 0, d_n = 0;
  int a_cyc[64];
  int b_cyc[64];
  int d_cyc[64];
  logic prev_a = 1'b0;
  logic b2b = 1'b0;
  logic nonuni = 1'b0;

  always #5 clk = ~clk;

  sgd_loss_sched #(
    .ENGINE_NUM   (EN),
    .B_LAT        (6),
    .SKEW_TIMEOUT (64),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_samples (num_samples),
    .gap_cfg     (gap_cfg),
    .a_empty     (a_empty),
    .b_empty     (b_empty),
    .a_rd_en     (a_rd_en),
    .b_rd_en     (b_rd_en),
    .busy        (busy),
    .done        (done),
    .issued_cnt  (issued_cnt),
    .skew_err    (skew_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_rd_en[0] && a_n < 64) begin
      a_cyc[a_n] <= cyc;
      a_n <= a_n + 1;
    end
    if (b_rd_en && b_n < 64) begin
      b_cyc[b_n] <= cyc;
      b_n <= b_n + 1;
    end
    if (done && d_n < 64) begin
      d_cyc[d_n] <= cyc;
      d_n <= d_n + 1;
    end
    if (a_rd_en != '0 && a_rd_en != '1) nonuni <= 1'b1;
    if (a_rd_en[0] && prev_a) b2b <= 1'b1;
    prev_a <= a_rd_en[0];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_epoch(input logic [CW-1:0] n, input logic [3:0] g, output int t0);
    @(posedge clk);
    #1 start = 1'b1;
    num_samples = n;
    gap_cfg = g;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int dbase, input int max, input string tag);
    int i = 0;
    while (d_n == dbase && i < max) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk(tag, 64'(d_n != dbase), 64'd1);
  endtask

  task automatic wait_pops(input int target, input int max, input string tag);
    int i = 0;
    while (a_n < target && i < max) begin
      @(posedge clk);
      i++;
    end
    chk(tag, 64'(a_n >= target), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, ab, bb, db, lat, any_pop;

    rst = 1'b1; start = 1'b0; abort = 1'b0; num_samples = '0;
    gap_cfg = 4'd2; a_empty = '1; b_empty = 1'b1;
    #23;
    chk("reset_outputs", 64'({a_rd_en, b_rd_en, busy, done, issued_cnt, skew_err}), 64'd0);
    rst = 1'b0;
    a_empty = '0; b_empty = 1'b0;
    repeat (2) @(posedge clk);

    // basic epoch
    ab = a_n; bb = b_n; db = d_n;
    start_epoch(32'd4, 4'd2, t0);
    wait_done(db, 100, "basic_done_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("basic_pops", 64'(a_n - ab), 64'd4);
    chk("basic_first_lat", 64'(a_cyc[ab] - t0), 64'd1);
    for (int i = 0; i < 3; i++)
      chk("basic_spacing", 64'(a_cyc[ab+i+1] - a_cyc[ab+i]), 64'd2);
    for (int i = 0; i < 4; i++)
      chk("basic_b_lag", 64'(b_cyc[bb+i] - a_cyc[ab+i]), 64'd6);
    chk("basic_b_pops", 64'(b_n - bb), 64'd4);
    chk("basic_done_lag", 64'(d_cyc[db] - b_cyc[bb+3]), 64'd1);
    chk("basic_done_count", 64'(d_n - db), 64'd1);
    chk("basic_issued", 64'(issued_cnt), 64'd4);
    chk("basic_busy_idle", 64'(busy), 64'd0);

    // gap clamp plus an ignored start while busy
    ab = a_n; db = d_n;
    start_epoch(32'd3, 4'd0, t0);
    chk("clamp_busy", 64'(busy), 64'd1);
    start = 1'b1; num_samples = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(db, 100, "clamp_done_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("clamp_pops", 64'(a_n - ab), 64'd3);
    chk("clamp_spacing0", 64'(a_cyc[ab+1] - a_cyc[ab]), 64'd2);
    chk("clamp_spacing1", 64'(a_cyc[ab+2] - a_cyc[ab+1]), 64'd2);
    chk("clamp_issued", 64'(issued_cnt), 64'd3);
    chk("clamp_no_b2b", 64'(b2b), 64'd0);

    // starvation on b
    ab = a_n; db = d_n;
    start_epoch(32'd5, 4'd2, t0);
    wait_pops(ab + 2, 50, "starve_pre_timeout");
    #1 b_empty = 1'b1;
    any_pop = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (a_rd_en[0]) any_pop = 1;
    end
    chk("starve_no_pop", 64'(any_pop), 64'd0);
    b_empty = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(posedge clk);
      #1 if (a_rd_en[0]) lat = i;
    end
    chk("starve_resume", 64'(lat >= 1 && lat <= 2), 64'd1);
    wait_done(db, 100, "starve_done_timeout");
    chk("starve_pops", 64'(a_n - ab), 64'd5);
    chk("starve_issued", 64'(issued_cnt), 64'd5);

    // engine skew
    a_empty = 8'h01;
    ab = a_n;
    start_epoch(32'd20, 4'd2, t0);
    repeat (63) @(posedge clk);
    #1 chk("skew_before_64", 64'(skew_err), 64'd0);
    @(posedge clk);
    #1 chk("skew_at_64", 64'(skew_err), 64'd1);
    repeat (5) @(posedge clk);
    #1 chk("skew_sticky", 64'(skew_err), 64'd1);
    chk("skew_no_pop", 64'(a_n - ab), 64'd0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    a_empty = '0;
    db = d_n;
    start_epoch(32'd1, 4'd2, t0);
    chk("skew_cleared_by_start", 64'(skew_err), 64'd0);
    wait_done(db, 100, "skew_done_timeout");

    // start and abort together in IDLE
    @(posedge clk);
    #1 start = 1'b1; abort = 1'b1; num_samples = 32'd5;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd0);

    // abort mid-epoch
    ab = a_n; bb = b_n; db = d_n;
    start_epoch(32'd10, 4'd4, t0);
    wait_pops(ab + 3, 60, "abort_pre_timeout");
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_spacing", 64'(a_cyc[ab+1] - a_cyc[ab]), 64'd4);
    chk("abort_pops", 64'(a_n - ab), 64'd3);
    chk("abort_b_pops", 64'(b_n - bb), 64'd2);
    chk("abort_no_done", 64'(d_n - db), 64'd0);
    chk("abort_issued", 64'(issued_cnt), 64'd3);

    // zero-sample epoch
    ab = a_n; db = d_n;
    start_epoch(32'd0, 4'd2, t0);
    wait_done(db, 20, "zero_done_timeout");
    chk("zero_done_lat", 64'(d_cyc[db] - t0), 64'd1);
    chk("zero_pops", 64'(a_n - ab), 64'd0);

    // async reset during DRAIN
    ab = a_n; bb = b_n;
    start_epoch(32'd2, 4'd2, t0);
    wait_pops(ab + 2, 40, "rst_pre_timeout");
    #1 chk("rst_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", 64'({a_rd_en, b_rd_en, busy, done, issued_cnt, skew_err}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_no_b_after", 64'(b_n - bb), 64'd0);
    chk("rst_pops", 64'(a_n - ab), 64'd2);

    chk("a_rd_en_uniform", 64'(nonuni), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sgd_loss_sched.md
Name: sgd_loss_sched

Overview:
- Read-side scheduler for the serial loss datapath.
- Decides when to pop all per-engine dot-product FIFOs together and when to pop the label (b) FIFO.
- Delays the b pop by a fixed latency so that b lines up with the adder-tree output.
- Counts issued samples per epoch, flags engine skew, and signals epoch completion to the upstream control logic.

Parameters:
- ENGINE_NUM, 8, number of engine dot-product FIFOs (same value as the shared define).
- B_LAT, 6, cycles from an a-pop to the matching b-pop (FIFO read plus register stages plus adder tree depth).
- SKEW_TIMEOUT, 64, cycles a partial-non-empty condition may persist before error is raised.
- CNT_W, 32, width of the sample counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins an epoch; ignored unless in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE.
- num_samples  in  CNT_W  samples per epoch; sampled on start.
- gap_cfg  in  4  minimum cycles between pops; values 0 and 1 are treated as 2.
- a_empty  in  ENGINE_NUM  empty flags of the engine FIFOs.
- b_empty  in  1  empty flag of the b FIFO.
- a_rd_en  out  ENGINE_NUM  pop strobe; all bits always identical.
- b_rd_en  out  1  b-FIFO pop strobe.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at epoch end.
- issued_cnt  out  CNT_W  a-pops issued in the current epoch.
- skew_err  out  1  sticky engine-skew error.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; delay line cleared.
- States and transitions:
  - IDLE: on start, latch num_samples, clear issued_cnt and skew_err. Go to DRAIN if num_samples==0, otherwise go to RUN.
  - RUN: a pop is issued in a cycle when all of the following hold: a_empty==0, b_empty==0, gap counter expired, and issued_cnt < latched N.
    - On a pop, a_rd_en = all-ones for 1 cycle, issued_cnt increments, and the gap counter reloads with max(gap_cfg,2)-1.
    - After the pop that makes issued_cnt==N, go to DRAIN on the next cycle.
  - DRAIN: no new pops. Stay until the b delay line is empty, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE. issued_cnt holds its value until the next start.
- b alignment: each a-pop enters a B_LAT-deep shift register. b_rd_en = shift register tail, so b_rd_en fires exactly B_LAT cycles after the corresponding a_rd_en, one pulse per pop.
- Minimum gap: the gap is never less than 2 cycles, which lets empty flags settle after a pop. There are no back-to-back pops.
- Skew detection (RUN only):
  - A skew cycle is one where a_empty is neither all-ones nor all-zeros.
  - The skew counter increments on each skew cycle and clears on any non-skew cycle.
  - When it reaches SKEW_TIMEOUT, skew_err is set. It is sticky until the next start or rst.
  - Scheduling continues while skew_err is set.
- abort:
  - In any state, abort forces IDLE next cycle and clears the delay line, so no further b_rd_en is issued.
  - Only a b_rd_en that coincides with the abort cycle still fires.
  - done is not pulsed; issued_cnt holds its value.
- start is ignored outside IDLE. start and abort in the same cycle: abort wins.
- Async rst mid-epoch: all outputs drop to 0 immediately, with no pending b pops.
- b_empty is checked at a-pop time. The pop is issued only if the b entry already exists; B_LAT only postpones its read.

Decomposition:
- Shared package: ENGINE_NUM, state enum {IDLE,RUN,DRAIN,DONE}, and a default B_LAT constant derived from the adder tree depth plus FIFO read latency.
- One sub-module, sgd_pulse_delay (parameterised depth shift register with clear), used for the b alignment.

Test Plan:
- Basic epoch: N=4, gap_cfg=2, FIFOs always non-empty, start at t0 → 4 a_rd_en pulses spaced exactly 2 cycles apart; 4 b_rd_en pulses each 6 cycles after its a-pop; done 1 cycle after the last b_rd_en; issued_cnt=4.
- Gap clamp: gap_cfg=0, N=3 → pops spaced 2 cycles, never 1.
- Starvation: b_empty=1 for 10 cycles mid-epoch → no a_rd_en during those cycles; resumes within one gap after b_empty falls; total pops still equals N.
- Skew: a_empty=8'h01 held for 64 cycles → skew_err rises on cycle 64 and stays high; no pop while the pattern holds; the next start clears it.
- Abort: abort 2 cycles after the 3rd a-pop with N=10 → busy=0 next cycle; no later b_rd_en; done never pulses; issued_cnt=3.
- Edge cases:
  - N=0 → no pops; done pulses 2 cycles after start.
  - start while busy → ignored.
  - rst asserted mid-DRAIN → all outputs 0 asynchronously.
